// File: rtl/spike_packer.sv
// Collects per-neuron spike events over one timestep into an N-bit bitmap, then
// streams it out LSB-first as N/WORD words on the sparse_bits valid/ready link.
module spike_packer #(
  parameter int N     = 128,
  parameter int WORD  = 32,
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             spk_valid,
  input  logic [IDX_W-1:0] spk_idx,
  output logic             spk_ready,
  input  logic             eof_valid,
  output logic             eof_ready,
  output logic [WORD-1:0]  sparse_bits,
  output logic             opt_valid,
  input  logic             opt_ready,
  output logic             opt_last,
  output logic [15:0]      frame_cnt,
  output logic             idx_err
);
  localparam int NW = N / WORD;
  localparam int CW = (NW > 1) ? $clog2(NW) : 1;

  typedef enum logic {COLLECT, SEND} state_t;
  state_t state, state_d;

  logic [NW-1:0][WORD-1:0] bitmap;
  logic [CW-1:0]           word_cnt;
  logic [N-1:0]            hit;
  logic                    spk_fire, eof_fire, opt_fire;

  // Shifting past bit N-1 gives an empty mask, which doubles as the range check.
  assign hit = N'(1) << spk_idx;

  always_comb begin
    state_d     = state;
    spk_ready   = 1'b0;
    eof_ready   = 1'b0;
    opt_valid   = 1'b0;
    opt_last    = 1'b0;
    sparse_bits = '0;
    case (state)
      COLLECT: begin
        spk_ready = 1'b1;
        eof_ready = 1'b1;
        if (eof_valid) state_d = SEND;
      end
      SEND: begin
        opt_valid   = 1'b1;
        sparse_bits = bitmap[word_cnt];
        opt_last    = (word_cnt == CW'(NW - 1));
        if (opt_ready && opt_last) state_d = COLLECT;
      end
      default: state_d = COLLECT;
    endcase
  end

  assign spk_fire = spk_valid & spk_ready;
  assign eof_fire = eof_valid & eof_ready;
  assign opt_fire = opt_valid & opt_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      bitmap    <= '0;
      word_cnt  <= '0;
      frame_cnt <= '0;
      idx_err   <= 1'b0;
    end else begin
      state <= state_d;
      if (spk_fire) begin
        if (|hit) bitmap <= bitmap | hit;
        else      idx_err <= 1'b1;
      end
      if (eof_fire) word_cnt <= '0;
      if (opt_fire) begin
        if (opt_last) begin
          bitmap    <= '0;
          word_cnt  <= '0;
          frame_cnt <= frame_cnt + 16'd1;
        end else begin
          word_cnt <= word_cnt + 1'b1;
        end
      end
    end
  end
endmodule
